vram_arbiter: RTL and testbench

//  Shares the single-port synchronous RAM between the video character fetcher and the CPU.

---
 rtl/vram_arbiter.sv | 111 +++++++++++
 tb/tb_vram_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the raster fetcher and the CPU.
// Video reads always win and have fixed latency; the CPU gets any cycle video leaves free.
module vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 1,
  parameter int STALL_W    = 16
) (
  input  logic               clk_pixel,
  input  logic               nreset,
  input  logic [AW-1:0]      vid_addr,
  input  logic               vid_rd,
  output logic [DW-1:0]      vid_dout,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_ack,
  output logic [DW-1:0]      cpu_rdata,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_en,
  output logic               ram_we,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_dout,
  input  logic               stall_clr,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, RDWAIT, ACK} state_t;

  typedef struct packed {
    logic vid;
    logic cpu;
  } tag_t;

  state_t state, state_nxt;
  tag_t [RD_LATENCY-1:0] tag_pipe;
  logic [DW-1:0] vid_hold;
  logic cpu_issue, cpu_rd_issue, vid_emerge, cpu_emerge;

  assign cpu_issue    = !vid_rd && (state == IDLE) && cpu_req;
  assign cpu_rd_issue = cpu_issue && !cpu_we;
  assign vid_emerge   = tag_pipe[RD_LATENCY-1].vid;
  assign cpu_emerge   = tag_pipe[RD_LATENCY-1].cpu;
  assign ram_wdata    = cpu_wdata;
  assign vid_dout     = vid_emerge ? ram_dout : vid_hold;

  // Tags ride alongside the RAM read so each returning word finds its owner.
  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset) begin
      tag_pipe <= '0;
    end else begin
      for (int i = RD_LATENCY-1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
      tag_pipe[0] <= '{vid: vid_rd, cpu: cpu_rd_issue};
    end
  end

  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_issue) state_nxt = cpu_we ? ACK : RDWAIT;
      RDWAIT:  if (cpu_emerge) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack  = (state == ACK);
    ram_addr = vid_addr;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    if (vid_rd) begin
      ram_en = 1'b1;
    end else if (cpu_issue) begin
      ram_addr = cpu_addr;
      ram_en   = 1'b1;
      ram_we   = cpu_we;
    end
    // Keep the macro quiet while held in reset, whatever the requesters do.
    if (!nreset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset) begin
      cpu_rdata <= '0;
      vid_hold  <= '0;
    end else begin
      if (state == RDWAIT && cpu_emerge) cpu_rdata <= ram_dout;
      if (vid_emerge)                    vid_hold  <= ram_dout;
    end
  end

  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (state == IDLE && cpu_req && vid_rd && !(&stall_cnt))
      stall_cnt <= stall_cnt + STALL_W'(1);
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural RAM of read latency L.
module tb_vram_arbiter;
  localparam int AW = 16, DW = 8, L = 2, SW = 16;

  logic clk_pixel = 1'b0, nreset = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, ram_addr;
  logic vid_rd = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, stall_clr = 1'b0;
  logic [DW-1:0] cpu_wdata = '0, vid_dout, cpu_rdata, ram_wdata, ram_dout;
  logic cpu_ack, ram_en, ram_we;
  logic [SW-1:0] stall_cnt;

  int checks = 0, errors = 0;
  logic we_seen = 1'b0, mon_we = 1'b0, ack_seen = 1'b0, mon_ack = 1'b0;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] rd_q [0:L-1];

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(L), .STALL_W(SW)) dut (
    .clk_pixel(clk_pixel), .nreset(nreset), .vid_addr(vid_addr), .vid_rd(vid_rd),
    .vid_dout(vid_dout), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_dout(ram_dout),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt));

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  initial for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));

  // RAM model: write on enable, read data appears L cycles after the address.
  always @(posedge clk_pixel) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rd_q[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
  end
  assign ram_dout = rd_q[L-1];

  always @(posedge clk_pixel) begin
    if (mon_we && ram_we) we_seen <= 1'b1;
    if (mon_ack && cpu_ack) ack_seen <= 1'b1;
  end

  task automatic cpu_wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_pixel); #1;
      if (cpu_ack === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk_pixel); #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", cpu_ack); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall got %h exp 0000", stall_cnt); end
    checks++; if (vid_dout !== 8'h00) begin errors++; $display("FAIL reset_vid_dout got %h exp 00", vid_dout); end
    vid_rd = 1'b1; cpu_req = 1'b1; #1;
    checks++; if ({ram_en, ram_we} !== 2'b00) begin errors++; $display("FAIL reset_ram_en got %b exp 00", {ram_en, ram_we}); end
    @(negedge clk_pixel); vid_rd = 1'b0; cpu_req = 1'b0; nreset = 1'b1;
  endtask

  task automatic test_video_only;
    mon_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pixel); vid_rd = 1'b1; vid_addr = 16'hF600 + 16'(k); #1;
      checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, vid_addr}) begin
        errors++; $display("FAIL vid_issue got %b%b %h exp 10 %h", ram_en, ram_we, ram_addr, vid_addr); end
      for (int c = 1; c < 8; c++) begin
        @(negedge clk_pixel); vid_rd = 1'b0; #1;
        if (c == L || c == 7) begin
          checks++; if (vid_dout !== pat(vid_addr)) begin
            errors++; $display("FAIL vid_dout c%0d got %h exp %h", c, vid_dout, pat(vid_addr)); end
        end
      end
    end
    mon_we = 1'b0;
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL vid_ram_we got %b exp 0", we_seen); end
  endtask

  task automatic test_cpu_write;
    int lat;
    @(negedge clk_pixel); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A; #1;
    checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h1234, 8'h5A}) begin
      errors++; $display("FAIL wr_issue got %b%b %h %h exp 11 1234 5a", ram_en, ram_we, ram_addr, ram_wdata); end
    cpu_wait_ack(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_ack_lat got %0d exp 1", lat); end
    @(negedge clk_pixel); cpu_req = 1'b0; cpu_we = 1'b0; #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b exp 0", cpu_ack); end
    checks++; if (mem[16'h1234] !== 8'h5A) begin errors++; $display("FAIL wr_mem got %h exp 5a", mem[16'h1234]); end
  endtask

  task automatic test_collision;
    @(negedge clk_pixel); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    vid_rd = 1'b1; vid_addr = 16'h0800; #1;
    checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 16'h0800}) begin
      errors++; $display("FAIL col_vid_wins got %b%b %h exp 10 0800", ram_en, ram_we, ram_addr); end
    @(negedge clk_pixel); vid_rd = 1'b0; #1;
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL col_stall got %0d exp 1", stall_cnt); end
    checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 16'h0400}) begin
      errors++; $display("FAIL col_cpu_issue got %b%b %h exp 10 0400", ram_en, ram_we, ram_addr); end
    @(negedge clk_pixel); #1;
    checks++; if (vid_dout !== pat(16'h0800)) begin errors++; $display("FAIL col_vid_dout got %h exp %h", vid_dout, pat(16'h0800)); end
    @(negedge clk_pixel); #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL col_early_ack got %b exp 0", cpu_ack); end
    @(negedge clk_pixel); #1;
    checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, pat(16'h0400)}) begin
      errors++; $display("FAIL col_ack got %b %h exp 1 %h", cpu_ack, cpu_rdata, pat(16'h0400)); end
    @(negedge clk_pixel); cpu_req = 1'b0; #1;
    checks++; if ({cpu_ack, cpu_rdata} !== {1'b0, pat(16'h0400)}) begin
      errors++; $display("FAIL col_hold got %b %h exp 0 %h", cpu_ack, cpu_rdata, pat(16'h0400)); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk_pixel); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2345;
    @(negedge clk_pixel); vid_rd = 1'b1; vid_addr = 16'h3456; #1;
    checks++; if ({ram_en, ram_addr} !== {1'b1, 16'h3456}) begin
      errors++; $display("FAIL b2b_vid_issue got %b %h exp 1 3456", ram_en, ram_addr); end
    @(negedge clk_pixel); vid_rd = 1'b0;
    @(negedge clk_pixel); #1;
    checks++; if (vid_dout !== pat(16'h3456)) begin errors++; $display("FAIL b2b_vid_dout got %h exp %h", vid_dout, pat(16'h3456)); end
    checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, pat(16'h2345)}) begin
      errors++; $display("FAIL b2b_cpu got %b %h exp 1 %h", cpu_ack, cpu_rdata, pat(16'h2345)); end
    @(negedge clk_pixel); cpu_req = 1'b0; #1;
    checks++; if (vid_dout !== pat(16'h3456)) begin errors++; $display("FAIL b2b_vid_hold got %h exp %h", vid_dout, pat(16'h3456)); end
  endtask

  task automatic test_reset_rdwait;
    int lat;
    @(negedge clk_pixel); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1111;
    @(negedge clk_pixel); nreset = 1'b0; vid_rd = 1'b1; #1;
    checks++; if ({ram_en, ram_we} !== 2'b00) begin errors++; $display("FAIL rst_ram_en got %b exp 00", {ram_en, ram_we}); end
    @(negedge clk_pixel); cpu_req = 1'b0; vid_rd = 1'b0;
    @(negedge clk_pixel); nreset = 1'b1; ack_seen = 1'b0; mon_ack = 1'b1;
    repeat (L + 3) @(negedge clk_pixel);
    mon_ack = 1'b0; #1;
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %b exp 0", ack_seen); end
    checks++; if ({cpu_rdata, vid_dout} !== 16'h0000) begin
      errors++; $display("FAIL rst_regs got %h %h exp 00 00", cpu_rdata, vid_dout); end
    @(negedge clk_pixel); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'hC3; #1;
    checks++; if ({ram_en, ram_we} !== 2'b11) begin errors++; $display("FAIL rst_idle_issue got %b exp 11", {ram_en, ram_we}); end
    cpu_wait_ack(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_idle_ack got %0d exp 1", lat); end
    @(negedge clk_pixel); cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_stall_sat;
    @(negedge clk_pixel); stall_clr = 1'b1;
    @(negedge clk_pixel); stall_clr = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; vid_rd = 1'b1;
    repeat (70000) @(negedge clk_pixel);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h exp ffff", stall_cnt); end
    stall_clr = 1'b1;
    @(negedge clk_pixel); #1;
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL stall_clr got %h exp 0000", stall_cnt); end
    cpu_req = 1'b0; vid_rd = 1'b0; stall_clr = 1'b0;
  endtask

  initial begin
    test_reset;
    test_video_only;
    test_cpu_write;
    test_collision;
    test_back_to_back;
    test_reset_rdwait;
    test_stall_sat;
    repeat (2) @(negedge clk_pixel);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
